// File: rtl/pcm_chan_buf.sv
// Ping-pong per-channel PCM store with serialiser, idle-code fill and overrun/underrun flags.
// Latency: frame_start to first serial bit is 2 clk minimum; afterwards one bit per bit_en.
// Backpressure: none; bit_en paces the output, and a frame_start during LOAD/SHIFT aborts the frame and sets overrun.
module pcm_chan_buf #(
    parameter int            NUM_CH    = 8,
    parameter int            DW        = 8,
    parameter int            CH_W      = 3,
    parameter logic [DW-1:0] IDLE_CODE = 8'hD5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [DW-1:0]   wr_data,
    input  logic            frame_start,
    input  logic            bit_en,
    input  logic            err_clr,
    input  logic            test_mode,
    input  logic            scan_enable,
    output logic            s_data,
    output logic            s_fs,
    output logic            busy,
    output logic            underrun,
    output logic            overrun
);

    localparam int              BC_W     = $clog2(NUM_CH * DW) + 1;
    localparam int              BP_W     = $clog2(DW) + 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(NUM_CH * DW - 1);
    localparam logic [BP_W-1:0] LAST_BP  = BP_W'(DW - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [DW-1:0]     mem   [0:1][0:NUM_CH-1];
    logic [NUM_CH-1:0] valid [0:1];
    logic              wbank;
    logic              rbank;
    logic [1:0]        state;
    logic [BC_W-1:0]   bit_cnt;
    logic [BP_W-1:0]   bpos;
    logic [CH_W-1:0]   ch_idx;
    logic [CH_W-1:0]   rd_ch;
    logic [DW-1:0]     sh;
    logic [DW-1:0]     rd_word;
    logic              armed;
    logic              ur_chk;
    logic              unused_dft;

    // DFT pins have no functional effect.
    assign unused_dft = test_mode ^ scan_enable;

    // The serialiser always reads the bank that is not being written.
    assign rbank = ~wbank;
    assign busy  = (state != ST_IDLE);

    // Fetch channel 0 during LOAD, otherwise the channel after the one being shifted;
    // an unwritten (or nonexistent) channel reads as the idle code.
    always_comb begin
        rd_ch   = (state == ST_LOAD) ? '0 : ch_idx + CH_W'(1);
        rd_word = IDLE_CODE;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c) && valid[rbank][c]) begin
                rd_word = mem[rbank][c];
            end
        end
    end

    // Sample storage: writes land in the current write bank; channels >= NUM_CH never match.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && wr_ch == CH_W'(c)) begin
                mem[wbank][c] <= wr_data;
            end
        end
    end

    // Valid masks: set on write, incoming write bank cleared on the frame swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid[0] <= '0;
            valid[1] <= '0;
        end else begin
            if (frame_start) begin
                valid[~wbank] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && wr_ch == CH_W'(c)) begin
                    valid[wbank][c] <= 1'b1;
                end
            end
        end
    end

    // Bank swap, serialiser FSM and sticky error flags (a set beats err_clr).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbank    <= 1'b0;
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bpos     <= '0;
            ch_idx   <= '0;
            sh       <= '0;
            s_data   <= 1'b0;
            s_fs     <= 1'b0;
            armed    <= 1'b0;
            ur_chk   <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (err_clr) begin
                underrun <= 1'b0;
                overrun  <= 1'b0;
            end
            if (frame_start) begin
                // Any frame still in flight is dropped, not resumed.
                wbank  <= ~wbank;
                state  <= ST_LOAD;
                ur_chk <= armed;
                armed  <= 1'b1;
                if (state != ST_IDLE) begin
                    overrun <= 1'b1;
                end
            end else begin
                case (state)
                    ST_LOAD: begin
                        sh      <= rd_word;
                        bit_cnt <= '0;
                        bpos    <= '0;
                        ch_idx  <= '0;
                        state   <= ST_SHIFT;
                        if (ur_chk && !(&valid[rbank])) begin
                            underrun <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (bit_en) begin
                            s_data  <= sh[DW-1];
                            s_fs    <= (bit_cnt == '0);
                            bit_cnt <= bit_cnt + BC_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= ST_IDLE;
                            end else if (bpos == LAST_BP) begin
                                sh     <= rd_word;
                                bpos   <= '0;
                                ch_idx <= ch_idx + CH_W'(1);
                            end else begin
                                sh   <= {sh[DW-2:0], 1'b0};
                                bpos <= bpos + BP_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
